// File: rtl/ex_div.sv
// Iterative restoring divider for the EX stage (DIV/DIVU), one quotient bit per cycle.
// Holds the pipeline via stallreq_o while busy and parks results in DONE until EX advances.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  input  logic [5:0]       stall_i,
  output logic             stallreq_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;   // dividend magnitude, quotient bits shift in at the LSB
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             done_q;
  logic [WIDTH-1:0] result_lo_q;
  logic [WIDTH-1:0] result_hi_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  logic unused_stall;
  assign unused_stall = ^{stall_i[5:4], stall_i[2:0]};

  always_comb begin
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    q_bit   = ~diff[WIDTH];
    rem_nx  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx  = {dvd_q[WIDTH-2:0], q_bit};
    quo_fix = neg_quo_q ? -quo_nx : quo_nx;
    rem_fix = neg_rem_q ? -rem_nx : rem_nx;
    // The most negative value maps to itself, which yields the no-trap overflow result.
    dvd_abs = (signed_op_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    dvs_abs = (signed_op_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      done_q      <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
    end else if (annul_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              result_lo_q <= '1;
              result_hi_q <= dividend_i;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              dvd_q     <= dvd_abs;
              dvs_q     <= dvs_abs;
              rem_q     <= '0;
              cnt_q     <= '0;
              neg_quo_q <= signed_op_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
              neg_rem_q <= signed_op_i & dividend_i[WIDTH-1];
              state_q   <= StBusy;
            end
          end
        end
        StBusy: begin
          rem_q <= rem_nx;
          dvd_q <= quo_nx;
          cnt_q <= cnt_q + CntOne;
          if (cnt_q == LastStep) begin
            result_lo_q <= quo_fix;
            result_hi_q <= rem_fix;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (!stall_i[3]) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign stallreq_o  = rst_ni & ~annul_i &
                       (((state_q == StIdle) & start_i) | (state_q == StBusy));
  assign done_o      = done_q;
  assign result_lo_o = result_lo_q;
  assign result_hi_o = result_hi_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, divide-by-zero,
// annul, downstream stall, back-to-back issue and asynchronous reset.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic [5:0]  stall;
  logic        stallreq;
  logic        done;
  logic [31:0] res_lo;
  logic [31:0] res_hi;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .signed_op_i (signed_op),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .annul_i     (annul),
    .stall_i     (stall),
    .stallreq_o  (stallreq),
    .done_o      (done),
    .result_lo_o (res_lo),
    .result_hi_o (res_hi)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns at the falling edge of the first DONE cycle.
  task automatic run_div(input string tag, input logic sop, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall, input int exp_lat,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n_stall;
    int t_done;
    n_stall   = 0;
    t_done    = -1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    for (int c = 0; c < 40 && t_done < 0; c++) begin
      @(negedge clk);
      if (stallreq) n_stall++;
      if (done) t_done = c;
      else begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    check_eq({tag, "_stallreq_cycles"}, n_stall, exp_stall);
    check_eq({tag, "_done_latency"}, t_done, exp_lat);
    check_eq({tag, "_result_lo"}, res_lo, exp_lo);
    check_eq({tag, "_result_hi"}, res_hi, exp_hi);
  endtask

  // With stall[3]=0 the DONE cycle is the only one; returns #1 after the next edge.
  task automatic leave_done(input string tag);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_done;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    annul     = 1'b0;
    stall     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_stallreq", stallreq, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_lo", res_lo, 32'h0);
    check_eq("reset_hi", res_hi, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 33, 32'd14, 32'd2);
    leave_done("divu_100_7");
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    leave_done("div_m7_2");
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 33, 32'h8000_0000, 32'h0);
    leave_done("div_ovf");
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 33, 32'hFFFF_FFFD, 32'd1);
    leave_done("div_7_m2");
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 33, 33, 32'h0FFF_FFFF, 32'hF);
    leave_done("divu_big");
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1, 1, 32'hFFFF_FFFF, 32'd5);
    leave_done("divu_5_0");
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    leave_done("div_m5_0");

    // Annul at T+10 of a running divide.
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    start     = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c == 9) check_eq("annul_busy_stallreq", stallreq, 1'b1);
    end
    annul = 1'b1;
    #1;
    check_eq("annul_same_cycle_stallreq", stallreq, 1'b0);
    @(posedge clk);
    #1;
    annul = 1'b0;
    #1;
    check_eq("annul_idle_next", stallreq, 1'b0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("annul_done_never", n_done, 0);
    check_eq("annul_lo_held", res_lo, 32'hFFFF_FFFF);
    check_eq("annul_hi_held", res_hi, 32'hFFFF_FFFB);
    @(posedge clk);
    #1;
    run_div("after_annul", 1'b0, 32'd1000, 32'd10, 33, 33, 32'd100, 32'd0);
    leave_done("after_annul");

    // start and annul together in IDLE: nothing accepted.
    start = 1'b1;
    annul = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd7;
    #1;
    check_eq("start_annul_stallreq", stallreq, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    #1;
    check_eq("start_annul_not_busy", stallreq, 1'b0);
    @(posedge clk);
    #1;

    // Downstream stall holds DONE, then a back-to-back divide on release.
    stall = 6'b001000;
    run_div("divu_50_5", 1'b0, 32'd50, 32'd5, 33, 33, 32'd10, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("stall_done_held", done, 1'b1);
      check_eq("stall_lo_held", res_lo, 32'd10);
    end
    @(posedge clk);
    #1;
    stall    = '0;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    check_eq("release_done", done, 1'b1);
    check_eq("release_start_ignored", stallreq, 1'b0);
    @(posedge clk);
    #1;
    run_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 33, 33, 32'd3, 32'd0);
    leave_done("b2b_9_3");

    // Asynchronous reset in the middle of BUSY.
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    start     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("pre_reset_busy", stallreq, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_stallreq", stallreq, 1'b0);
    check_eq("async_rst_done", done, 1'b0);
    check_eq("async_rst_lo", res_lo, 32'h0);
    check_eq("async_rst_hi", res_hi, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    run_div("post_reset", 1'b0, 32'd1000, 32'd3, 33, 33, 32'd333, 32'd1);
    leave_done("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit divider for the EX stage. It serves DIV/DIVU from the operands latched in the ID/EX pipeline register, and it drives the EX stall request back to the pipeline controller. That request is what raises `stall[3:0]` and freezes ID/EX for the whole division. The block uses the same `stall[5:0]` vector as the pipeline registers: index 0 is PC, 5 is WB, and bit 3 is EX. It watches `stall[3]` to know when the finished instruction has left EX.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported.

Ports:
- `clk` in 1: clock. Everything happens on the rising edge.
- `rst` in 1: reset. Asynchronous and active-low.
- `start` in 1: EX holds a DIV/DIVU instruction.
- `signed_op` in 1: 1 = DIV (signed), 0 = DIVU.
- `dividend` in 32: dividend operand (`opv1`).
- `divisor` in 32: divisor operand (`opv2`).
- `annul` in 1: flush. Aborts any operation in progress.
- `stall` in 6: pipeline stall vector. Only bit 3 is used.
- `stallreq` out 1: EX stall request to the controller. Combinational.
- `done` out 1: result valid. Registered.
- `result_lo` out 32: quotient. Registered.
- `result_hi` out 32: remainder. Registered.

## Operation
States are IDLE, BUSY and DONE.

- **IDLE, `start`=1, `annul`=0, `divisor`≠0:**
  - Latch |dividend|, |divisor|, the quotient sign (sign(dividend) XOR sign(divisor), signed mode only) and the remainder sign (sign(dividend), signed mode only).
  - Clear the partial remainder and the step counter.
  - Go to BUSY.
- **IDLE, `start`=1, `annul`=0, `divisor`=0:**
  - Load `result_lo`=0xFFFFFFFF and `result_hi`=`dividend`.
  - Go to DONE. No iteration is performed.
- **BUSY:** one restoring step per cycle, with a 33-bit partial remainder.
  - Shift in the next dividend MSB.
  - Trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit.
  - At the edge where the counter equals 31, apply sign correction and load the results:
    - quotient is two's-complement negated if its sign flag is set;
    - remainder is negated if its sign flag is set.
  - Go to DONE.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives `result_lo`=0x80000000 and `result_hi`=0, with no trap. This falls out of 32-bit unsigned magnitude arithmetic.
- **DONE:** `done`=1.
  - If `stall[3]`=1, stay in DONE with the results held.
  - If `stall[3]`=0, the instruction leaves EX: go to IDLE.
  - `start` is ignored in DONE. A back-to-back divide is accepted in IDLE on the next cycle.
- **`stallreq`** = (IDLE & `start` & !`annul`) | (BUSY & !`annul`). It is 0 in DONE and 0 while `rst` is low.
- **`annul`:** from any state, the next state is IDLE and `done` clears. `result_lo`/`result_hi` are not updated by the aborted operation.
- **Results:** `result_lo`/`result_hi` change only on a DONE entry and hold otherwise.

## Timing
- **Reset:** state IDLE, counter 0, `done`=0, `result_lo`=0, `result_hi`=0, `stallreq`=0. Applied immediately, without a clock, including mid-BUSY.
- **Latency (non-zero divisor):** start accepted in cycle T; BUSY in T+1..T+32; DONE visible in T+33. `stallreq` is high for exactly 33 cycles (T..T+32), low from T+33.
- **Latency (zero divisor):** `stallreq` high in T only; DONE in T+1.
- **`annul` in cycle A:** `stallreq`=0 in A; IDLE in A+1.
- **Same-cycle `start` and `annul` in IDLE:** `annul` wins; nothing is accepted.

## Test plan
- **DIVU 100 / 7:** `result_lo`=14, `result_hi`=2. `stallreq` high cycles T..T+32. `done` rises at T+33; with `stall[3]`=0 it is high for exactly 1 cycle.
- **Signed division:**
  - DIV −7 / 2 → `result_lo`=0xFFFFFFFD, `result_hi`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `result_lo`=0x80000000, `result_hi`=0.
- **Divide by zero:** DIVU 5 / 0 → `stallreq` high only in T; `done` at T+1; `result_lo`=0xFFFFFFFF, `result_hi`=5.
- **Annul mid-operation:** `annul` at T+10 → `stallreq`=0 in the same cycle, IDLE next, `done` never asserts, results unchanged. A fresh start after that completes in 33 cycles.
- **Downstream stall and back-to-back divides:** hold `stall[3]`=1 for 3 cycles in DONE → `done` and the results stay stable. Release it with a new DIVU 9 / 3 at `start` → accepted the next cycle; `result_lo`=3, `result_hi`=0 at +33.
- **Reset mid-operation:** assert `rst` low asynchronously mid-BUSY → `stallreq`, `done`, `result_lo` and `result_hi` are all 0 before the next edge.
